// File: rtl/mtm_alu_frame_rx_pkg.sv
// Shared types and line-level constants for the bit-serial frame receiver.
package mtm_alu_frame_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    DATA      = 2'd2,
    STOP      = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/mtm_alu_sync_fifo.sv
// Synchronous FIFO with level output; head data reads as zero while empty.
module mtm_alu_sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is still legal.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_frame_rx.sv
// Bit-serial frame receiver: start/payload/stop deframing, stop-bit check,
// and buffered payload delivery over a valid/ready handshake.
module mtm_alu_frame_rx
  import mtm_alu_frame_rx_pkg::*;
#(
  parameter int PKT_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sin,
  output logic [PKT_W-1:0]                  pkt_data,
  output logic                              pkt_valid,
  input  logic                              pkt_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              err_frame,
  output logic                              err_overflow
);

  localparam int CNT_W = $clog2(PKT_W + 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PKT_W-1:0]  shreg_q, shreg_d;
  logic              err_frame_q, err_frame_d;
  logic              err_ovf_q, err_ovf_d;
  logic              good_frame, push, fifo_full, fifo_empty, last_bit;

  assign last_bit = (cnt_q == CNT_W'(PKT_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (sin == STOP_BIT)  state_d = IDLE;
      IDLE:      if (sin == START_BIT) state_d = DATA;
      DATA:      if (last_bit)         state_d = STOP;
      STOP:      state_d = (sin == STOP_BIT) ? IDLE : WAIT_IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    good_frame  = 1'b0;
    err_frame_d = 1'b0;
    case (state_q)
      IDLE: cnt_d = '0;
      DATA: begin
        if (MSB_FIRST) shreg_d = {shreg_q[PKT_W-2:0], sin};
        else           shreg_d = {sin, shreg_q[PKT_W-1:1]};
        if (cnt_q != CNT_W'(PKT_W)) cnt_d = cnt_q + CNT_W'(1);
      end
      STOP: begin
        good_frame  = (sin == STOP_BIT);
        err_frame_d = (sin != STOP_BIT);
      end
      default: ;
    endcase
  end

  // Full only blocks the push when the consumer is not taking the head this cycle.
  assign push      = good_frame && (!fifo_full || pkt_ready);
  assign err_ovf_d = good_frame && fifo_full && !pkt_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      shreg_q     <= '0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      err_frame_q <= err_frame_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  mtm_alu_sync_fifo #(
    .DATA_W (PKT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_q),
    .pop       (pkt_ready),
    .pop_data  (pkt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pkt_valid    = !fifo_empty;
  assign err_frame    = err_frame_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Directed bench for mtm_alu_frame_rx: MSB-first and LSB-first instances share one serial line.
module tb_mtm_alu_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       pkt_ready;
  logic [9:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic [2:0] level_m, level_l;
  logic       ferr_m, ferr_l, ovf_m, ovf_l;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0] payload;
    logic       rdy;
    logic       exp_valid;
    logic [9:0] exp_data;
    logic [2:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mtm_alu_frame_rx #(.PKT_W(10), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .sin(sin),
    .pkt_data(data_m), .pkt_valid(valid_m), .pkt_ready(pkt_ready),
    .fifo_level(level_m), .err_frame(ferr_m), .err_overflow(ovf_m)
  );

  mtm_alu_frame_rx #(.PKT_W(10), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .sin(sin),
    .pkt_data(data_l), .pkt_valid(valid_l), .pkt_ready(pkt_ready),
    .fifo_level(level_l), .err_frame(ferr_l), .err_overflow(ovf_l)
  );

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] p, input logic stopb, input logic rdy);
    send_bit(1'b0);
    for (int i = 9; i >= 0; i--) send_bit(p[i]);
    pkt_ready = rdy;
    send_bit(stopb);
    pkt_ready = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      send_frame(tbl[r].payload, 1'b1, tbl[r].rdy);
      check($sformatf("row%0d_valid", r), 32'(valid_m), 32'(tbl[r].exp_valid));
      check($sformatf("row%0d_data", r),  32'(data_m),  32'(tbl[r].exp_data));
      check($sformatf("row%0d_level", r), 32'(level_m), 32'(tbl[r].exp_level));
      check($sformatf("row%0d_ovf", r),   32'(ovf_m),   32'(tbl[r].exp_ovf));
      check($sformatf("row%0d_ferr", r),  32'(ferr_m),  32'd0);
      check($sformatf("row%0d_lsb_data", r), 32'(data_l), 32'(rev10(tbl[r].exp_data)));
    end
  endtask

  task automatic drain_expect(input int first, input int n);
    pkt_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("drain%0d_data", k), 32'(data_m), 32'(first + k));
      @(posedge clk);
      #1;
    end
    pkt_ready = 1'b0;
    check("drain_done_valid", 32'(valid_m), 32'd0);
    check("drain_done_level", 32'(level_m), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{10'h001, 1'b0, 1'b1, 10'h001, 3'd1, 1'b0};
    tbl[1] = '{10'h002, 1'b0, 1'b1, 10'h001, 3'd2, 1'b0};
    tbl[2] = '{10'h003, 1'b0, 1'b1, 10'h001, 3'd3, 1'b0};
    tbl[3] = '{10'h004, 1'b0, 1'b1, 10'h001, 3'd4, 1'b0};
    tbl[4] = '{10'h005, 1'b0, 1'b1, 10'h001, 3'd4, 1'b1};
    tbl[5] = '{10'h001, 1'b0, 1'b1, 10'h001, 3'd1, 1'b0};
    tbl[6] = '{10'h002, 1'b0, 1'b1, 10'h001, 3'd2, 1'b0};
    tbl[7] = '{10'h003, 1'b0, 1'b1, 10'h001, 3'd3, 1'b0};
    tbl[8] = '{10'h004, 1'b0, 1'b1, 10'h001, 3'd4, 1'b0};
    tbl[9] = '{10'h005, 1'b1, 1'b1, 10'h002, 3'd4, 1'b0};

    sin = 1'b1;
    pkt_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  32'(data_m),  32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_level", 32'(level_m), 32'd0);
    check("rst_ferr",  32'(ferr_m),  32'd0);
    check("rst_ovf",   32'(ovf_m),   32'd0);
    rst = 1'b1;
    send_bit(1'b1);

    // Single frame, both bit orders
    send_frame(10'h2C3, 1'b1, 1'b0);
    check("single_valid", 32'(valid_m), 32'd1);
    check("single_data",  32'(data_m),  32'h2C3);
    check("single_level", 32'(level_m), 32'd1);
    check("single_ferr",  32'(ferr_m),  32'd0);
    check("single_ovf",   32'(ovf_m),   32'd0);
    check("lsb_data",     32'(data_l),  32'h30D);
    drain_expect(32'h2C3, 1);

    // Framing error, then line held low, then recovery
    send_frame(10'h155, 1'b0, 1'b0);
    check("ferr_pulse", 32'(ferr_m),  32'd1);
    check("ferr_level", 32'(level_m), 32'd0);
    check("ferr_valid", 32'(valid_m), 32'd0);
    send_bit(1'b0);
    check("ferr_one_cycle", 32'(ferr_m), 32'd0);
    repeat (4) send_bit(1'b0);
    check("low_hold_level", 32'(level_m), 32'd0);
    check("low_hold_ferr",  32'(ferr_m),  32'd0);
    send_bit(1'b1);
    send_frame(10'h001, 1'b1, 1'b0);
    check("recover_valid", 32'(valid_m), 32'd1);
    check("recover_data",  32'(data_m),  32'h001);
    check("recover_level", 32'(level_m), 32'd1);
    drain_expect(1, 1);

    // Back-to-back frames into a stalled consumer, overflow on the fifth
    run_rows(0, 4);
    send_bit(1'b1);
    check("ovf_one_cycle", 32'(ovf_m),   32'd0);
    check("ovf_level",     32'(level_m), 32'd4);
    drain_expect(1, 4);

    // Full FIFO with a pop in the same cycle as the fifth push
    run_rows(5, 9);
    drain_expect(2, 4);

    // Reset in the middle of a frame with two entries stored
    send_frame(10'h0AA, 1'b1, 1'b0);
    send_frame(10'h055, 1'b1, 1'b0);
    check("pre_rst_level", 32'(level_m), 32'd2);
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    sin = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_m), 32'd0);
    check("midrst_level", 32'(level_m), 32'd0);
    check("midrst_data",  32'(data_m),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) send_bit(1'b0);
    check("post_rst_valid", 32'(valid_m), 32'd0);
    check("post_rst_level", 32'(level_m), 32'd0);
    check("post_rst_ferr",  32'(ferr_m),  32'd0);
    send_bit(1'b1);
    send_frame(10'h3FF, 1'b1, 1'b0);
    check("final_data",     32'(data_m),  32'h3FF);
    check("final_level",    32'(level_m), 32'd1);
    check("final_valid",    32'(valid_m), 32'd1);
    check("final_lsb_data", 32'(data_l),  32'h3FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
